go_game_ctrl: RTL and testbench

- Parametrised Go game-control FSM; sequences turns, validates moves through an external board updater, owns the board and ko snapshot registers, and drives the UART/network transmit handshake.
- Adds configurable board size, N-consecutive-pass ending, resignation, a move cap, and a held tx handshake.
- Sits between the move source (keypad/UART rx) and board_updater, feeding board_bus to display and scoring logic.

---
 rtl/go_game_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_go_game_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/go_game_ctrl.sv
// go_game_ctrl
//   Turn sequencer for a Go game. It accepts moves from a move source,
//   has an external board updater validate placements, owns the current
//   board and the ko snapshot (board before the last placement), tracks
//   consecutive passes, placed-stone count and resignation, and drives a
//   held ready/ack transmit handshake for locally played moves.
//
//   Optional feature: define GO_MOVE_TIMER_EN to add a per-turn timer.
//   It adds parameter TURN_CYCLES and output port timeout. When the timer
//   expires in WAITING without a move, an automatic pass is played.
//
// Ports
//   clk_in         system clock
//   reset          synchronous active-high reset
//   move_avail     one-cycle strobe, move is valid
//   move           {row,col}; all-ones = pass, all-ones with LSB 0 = resign
//   my_color       local player colour (0 black, 1 white)
//   upd_valid      updater accepted move, upd_next_board valid
//   upd_invalid    updater rejected move (wins over upd_valid)
//   upd_next_board board produced by the updater
//   tx_ack         transmitter consumed tx_move
//   upd_start      one-cycle start strobe to the updater
//   upd_move       latched move presented to the updater
//   board_bus      current board, 2 bits per intersection, 00 empty
//   ko_board       board before the last placement
//   turn           colour to move (0 black)
//   tx_ready       tx_move valid, held until tx_ack
//   tx_move        move to transmit
//   invalid_move   one-cycle pulse on rejection
//   game_over      high in GAME_OVER
//   end_reason     00 none, 01 passes, 10 resign, 11 move cap
//   move_count     placed stones
//   pass_count     consecutive passes (saturating)
//   state_out      one-hot state
//   timeout        (GO_MOVE_TIMER_EN only) pulse on turn timer expiry
module go_game_ctrl #(
    parameter int BOARD_SIZE  = 9,
    parameter int COORD_W     = 4,
    parameter int PASS_LIMIT  = 2,
    parameter int MAX_MOVES   = 512,
    parameter int CNT_W       = 10
`ifdef GO_MOVE_TIMER_EN
    ,
    parameter int TURN_CYCLES = 100_000_000
`endif
) (
    input  logic                                clk_in,
    input  logic                                reset,
    input  logic                                move_avail,
    input  logic [2*COORD_W-1:0]                move,
    input  logic                                my_color,
    input  logic                                upd_valid,
    input  logic                                upd_invalid,
    input  logic [2*BOARD_SIZE*BOARD_SIZE-1:0]  upd_next_board,
    input  logic                                tx_ack,
    output logic                                upd_start,
    output logic [2*COORD_W-1:0]                upd_move,
    output logic [2*BOARD_SIZE*BOARD_SIZE-1:0]  board_bus,
    output logic [2*BOARD_SIZE*BOARD_SIZE-1:0]  ko_board,
    output logic                                turn,
    output logic                                tx_ready,
    output logic [2*COORD_W-1:0]                tx_move,
    output logic                                invalid_move,
    output logic                                game_over,
    output logic [1:0]                          end_reason,
    output logic [CNT_W-1:0]                    move_count,
    output logic [1:0]                          pass_count,
    output logic [6:0]                          state_out
`ifdef GO_MOVE_TIMER_EN
    ,
    output logic                                timeout
`endif
);

    localparam int MW = 2 * COORD_W;
    localparam int BW = 2 * BOARD_SIZE * BOARD_SIZE;
    localparam logic [MW-1:0] PASS_CODE   = {MW{1'b1}};
    localparam logic [MW-1:0] RESIGN_CODE = {{(MW-1){1'b1}}, 1'b0};

    typedef enum logic [6:0] {
        S_WAITING        = 7'b0000001,
        S_CHECK          = 7'b0000010,
        S_UPDATE_BUS     = 7'b0000100,
        S_SENDING_MOVE   = 7'b0001000,
        S_PASS           = 7'b0010000,
        S_GAME_OVER_SEND = 7'b0100000,
        S_GAME_OVER      = 7'b1000000
    } state_t;

    state_t            state_q;
    logic              upd_start_q;
    logic [MW-1:0]     upd_move_q;
    logic [MW-1:0]     tx_move_q;
    logic [BW-1:0]     board_q;
    logic [BW-1:0]     ko_q;
    logic              turn_q;
    logic              tx_ready_q;
    logic              invalid_q;
    logic              game_over_q;
    logic [1:0]        end_reason_q;
    logic [CNT_W-1:0]  move_cnt_q;
    logic [1:0]        pass_cnt_q;

    logic [CNT_W-1:0]  move_cnt_d;
    logic [1:0]        pass_cnt_d;
    logic              local_turn;
    logic              tx_done;

    always_comb begin
        move_cnt_d = move_cnt_q + CNT_W'(1);
        pass_cnt_d = (pass_cnt_q == 2'd3) ? 2'd3 : pass_cnt_q + 2'd1;
        local_turn = (turn_q == my_color);
        // A send phase ends on the ack when the handshake is up, or
        // immediately when the move belongs to the remote player.
        tx_done    = tx_ready_q ? tx_ack : !local_turn;
    end

`ifdef GO_MOVE_TIMER_EN
    logic [31:0] timer_q;
    logic        timeout_q;

    // Held at zero outside WAITING, so every entry into WAITING starts a
    // fresh turn window.
    always_ff @(posedge clk_in) begin
        if (reset || state_q != S_WAITING) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign timeout = timeout_q;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= S_WAITING;
            upd_start_q  <= 1'b0;
            upd_move_q   <= '0;
            tx_move_q    <= '0;
            board_q      <= '0;
            ko_q         <= '0;
            turn_q       <= 1'b0;
            tx_ready_q   <= 1'b0;
            invalid_q    <= 1'b0;
            game_over_q  <= 1'b0;
            end_reason_q <= 2'b00;
            move_cnt_q   <= '0;
            pass_cnt_q   <= 2'd0;
`ifdef GO_MOVE_TIMER_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            upd_start_q <= 1'b0;
            invalid_q   <= 1'b0;
`ifdef GO_MOVE_TIMER_EN
            timeout_q   <= 1'b0;
`endif
            case (state_q)
                S_WAITING: begin
                    if (move_avail) begin
                        upd_move_q <= move;
                        tx_move_q  <= move;
                        if (move == PASS_CODE) begin
                            state_q <= S_PASS;
                        end else if (move == RESIGN_CODE) begin
                            end_reason_q <= 2'b10;
                            tx_ready_q   <= local_turn;
                            state_q      <= S_GAME_OVER_SEND;
                        end else begin
                            upd_start_q <= 1'b1;
                            state_q     <= S_CHECK;
                        end
                    end
`ifdef GO_MOVE_TIMER_EN
                    else if (timer_q == 32'(TURN_CYCLES - 1)) begin
                        upd_move_q <= PASS_CODE;
                        tx_move_q  <= PASS_CODE;
                        timeout_q  <= 1'b1;
                        state_q    <= S_PASS;
                    end
`endif
                end
                S_CHECK: begin
                    if (upd_invalid) begin
                        invalid_q <= 1'b1;
                        state_q   <= S_WAITING;
                    end else if (upd_valid) begin
                        state_q <= S_UPDATE_BUS;
                    end
                end
                S_UPDATE_BUS: begin
                    ko_q       <= board_q;
                    board_q    <= upd_next_board;
                    move_cnt_q <= move_cnt_d;
                    pass_cnt_q <= 2'd0;
                    tx_ready_q <= local_turn;
                    if (move_cnt_d == CNT_W'(MAX_MOVES)) begin
                        end_reason_q <= 2'b11;
                        state_q      <= S_GAME_OVER_SEND;
                    end else begin
                        state_q <= S_SENDING_MOVE;
                    end
                end
                S_PASS: begin
                    pass_cnt_q <= pass_cnt_d;
                    tx_ready_q <= local_turn;
                    if (int'(pass_cnt_d) >= PASS_LIMIT) begin
                        end_reason_q <= 2'b01;
                        state_q      <= S_GAME_OVER_SEND;
                    end else begin
                        state_q <= S_SENDING_MOVE;
                    end
                end
                S_SENDING_MOVE: begin
                    if (tx_done) begin
                        tx_ready_q <= 1'b0;
                        turn_q     <= ~turn_q;
                        state_q    <= S_WAITING;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                S_GAME_OVER_SEND: begin
                    if (tx_done) begin
                        tx_ready_q  <= 1'b0;
                        game_over_q <= 1'b1;
                        state_q     <= S_GAME_OVER;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                S_GAME_OVER: begin
                    tx_ready_q  <= 1'b0;
                    game_over_q <= 1'b1;
                end
                default: begin
                    state_q <= S_WAITING;
                end
            endcase
        end
    end

    assign upd_start    = upd_start_q;
    assign upd_move     = upd_move_q;
    assign board_bus    = board_q;
    assign ko_board     = ko_q;
    assign turn         = turn_q;
    assign tx_ready     = tx_ready_q;
    assign tx_move      = tx_move_q;
    assign invalid_move = invalid_q;
    assign game_over    = game_over_q;
    assign end_reason   = end_reason_q;
    assign move_count   = move_cnt_q;
    assign pass_count   = pass_cnt_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_go_game_ctrl.sv
module tb_go_game_ctrl;

    localparam int BS = 5;
    localparam int CW = 4;
    localparam int PL = 2;
    localparam int MM = 6;
    localparam int NW = 10;
    localparam int BW = 2 * BS * BS;
    localparam int MW = 2 * CW;
    localparam logic [MW-1:0] PASS_MV   = {MW{1'b1}};
    localparam logic [MW-1:0] RESIGN_MV = {{(MW-1){1'b1}}, 1'b0};

    localparam int EV_INV  = 0;
    localparam int EV_TX   = 1;
    localparam int EV_FLIP = 2;
    localparam int EV_OVER = 3;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          move_avail = 1'b0;
    logic [MW-1:0] move = '0;
    logic          my_color = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_invalid = 1'b0;
    logic [BW-1:0] upd_next_board = '0;
    logic          tx_ack = 1'b0;
    logic          upd_start;
    logic [MW-1:0] upd_move;
    logic [BW-1:0] board_bus;
    logic [BW-1:0] ko_board;
    logic          turn;
    logic          tx_ready;
    logic [MW-1:0] tx_move;
    logic          invalid_move;
    logic          game_over;
    logic [1:0]    end_reason;
    logic [NW-1:0] move_count;
    logic [1:0]    pass_count;
    logic [6:0]    state_out;
`ifdef GO_MOVE_TIMER_EN
    logic          timeout;
`endif

    go_game_ctrl #(
        .BOARD_SIZE (BS),
        .COORD_W    (CW),
        .PASS_LIMIT (PL),
        .MAX_MOVES  (MM),
        .CNT_W      (NW)
`ifdef GO_MOVE_TIMER_EN
        ,
        .TURN_CYCLES(1000)
`endif
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .move_avail     (move_avail),
        .move           (move),
        .my_color       (my_color),
        .upd_valid      (upd_valid),
        .upd_invalid    (upd_invalid),
        .upd_next_board (upd_next_board),
        .tx_ack         (tx_ack),
        .upd_start      (upd_start),
        .upd_move       (upd_move),
        .board_bus      (board_bus),
        .ko_board       (ko_board),
        .turn           (turn),
        .tx_ready       (tx_ready),
        .tx_move        (tx_move),
        .invalid_move   (invalid_move),
        .game_over      (game_over),
        .end_reason     (end_reason),
        .move_count     (move_count),
        .pass_count     (pass_count),
        .state_out      (state_out)
`ifdef GO_MOVE_TIMER_EN
        ,
        .timeout        (timeout)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int            kind;
        logic [MW-1:0] mv;
        logic          trn;
        int            mc;
        int            pc;
        logic [BW-1:0] bd;
        logic [BW-1:0] ko;
        logic [1:0]    er;
    } ev_t;

    ev_t q[$];

    // Reference model of the game at move granularity.
    logic          m_turn;
    int            m_mc;
    int            m_pc;
    logic [BW-1:0] m_bd;
    logic [BW-1:0] m_ko;
    bit            m_over;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [MW-1:0] mv, input logic [1:0] er);
        ev_t e;
        e.kind = k;
        e.mv   = mv;
        e.trn  = m_turn;
        e.mc   = m_mc;
        e.pc   = m_pc;
        e.bd   = m_bd;
        e.ko   = m_ko;
        e.er   = er;
        q.push_back(e);
    endfunction

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    // Monitor: each DUT-visible event pops the oldest expectation.
    task automatic expect_ev(input int k);
        ev_t e;
        if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
        end else begin
            e = q.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            if (k == e.kind) begin
                case (k)
                    EV_INV: begin
                        check("inv_turn", 64'(turn), 64'(e.trn));
                        check("inv_count", 64'(move_count), 64'(e.mc));
                        check("inv_board", 64'(board_bus), 64'(e.bd));
                        check("inv_state", 64'(state_out), 64'(7'b0000001));
                    end
                    EV_TX: begin
                        check("tx_move", 64'(tx_move), 64'(e.mv));
                        check("tx_turn", 64'(turn), 64'(e.trn));
                        check("tx_count", 64'(move_count), 64'(e.mc));
                        check("tx_board", 64'(board_bus), 64'(e.bd));
                    end
                    EV_FLIP: begin
                        check("flip_turn", 64'(turn), 64'(e.trn));
                        check("flip_count", 64'(move_count), 64'(e.mc));
                        check("flip_pass", 64'(pass_count), 64'(e.pc));
                        check("flip_board", 64'(board_bus), 64'(e.bd));
                        check("flip_ko", 64'(ko_board), 64'(e.ko));
                        check("flip_state", 64'(state_out), 64'(7'b0000001));
                        check("flip_txrdy", 64'(tx_ready), 64'(0));
                    end
                    default: begin
                        check("over_reason", 64'(end_reason), 64'(e.er));
                        check("over_turn", 64'(turn), 64'(e.trn));
                        check("over_count", 64'(move_count), 64'(e.mc));
                        check("over_pass", 64'(pass_count), 64'(e.pc));
                        check("over_board", 64'(board_bus), 64'(e.bd));
                        check("over_txrdy", 64'(tx_ready), 64'(0));
                    end
                endcase
            end
        end
    endtask

    initial begin
        logic p_turn;
        logic p_tx;
        logic p_go;
        p_turn = 1'b0;
        p_tx   = 1'b0;
        p_go   = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                if (invalid_move)          expect_ev(EV_INV);
                if (tx_ready && !p_tx)     expect_ev(EV_TX);
                if (turn !== p_turn)       expect_ev(EV_FLIP);
                if (game_over && !p_go)    expect_ev(EV_OVER);
            end
            p_turn = turn;
            p_tx   = tx_ready;
            p_go   = game_over;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return upd_start;
            1:       return tx_ready;
            default: return (state_out == 7'b0000001) || (state_out == 7'b1000000);
        endcase
    endfunction

    task automatic wait_for(input string nm, input int which, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (cond(which)) return;
            step();
        end
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected event within %0d cycles", nm, bound);
        summary_and_finish();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        move_avail  = 1'b0;
        upd_valid   = 1'b0;
        upd_invalid = 1'b0;
        tx_ack      = 1'b0;
        q.delete();
        step();
        step();
        reset  = 1'b0;
        m_turn = 1'b0;
        m_mc   = 0;
        m_pc   = 0;
        m_bd   = '0;
        m_ko   = '0;
        m_over = 1'b0;
        check("rst_state", 64'(state_out), 64'(7'b0000001));
        check("rst_board", 64'(board_bus), 64'(0));
        check("rst_ko", 64'(ko_board), 64'(0));
        check("rst_turn", 64'(turn), 64'(0));
        check("rst_txrdy", 64'(tx_ready), 64'(0));
        check("rst_start", 64'(upd_start), 64'(0));
        check("rst_over", 64'(game_over), 64'(0));
        check("rst_reason", 64'(end_reason), 64'(0));
        check("rst_count", 64'(move_count), 64'(0));
        check("rst_pass", 64'(pass_count), 64'(0));
        check("rst_invalid", 64'(invalid_move), 64'(0));
    endtask

    // Plays one move from WAITING; done=1 when the game ended or was reset.
    task automatic play_move(output bit done);
        logic [MW-1:0] mv;
        logic [BW-1:0] nb;
        bit            lcl;
        bit            acc;
        bit            both;
        bit            need_tx;
        int            r;
        int            d;

        done = 1'b0;
        r = $urandom_range(0, 99);
        if (r < 15)      mv = PASS_MV;
        else if (r < 20) mv = RESIGN_MV;
        else             mv = {CW'($urandom_range(0, BS - 1)), CW'($urandom_range(0, BS - 1))};
        nb = {$urandom, $urandom};
        my_color       = 1'($urandom_range(0, 1));
        upd_next_board = nb;
        move           = mv;
        move_avail     = 1'b1;
        step();
        move_avail = 1'b0;
        move       = MW'($urandom);

        lcl     = (m_turn == my_color);
        need_tx = lcl;
        acc     = 1'b0;
        both    = 1'b0;
        if (mv == PASS_MV) begin
            m_pc = (m_pc == 3) ? 3 : m_pc + 1;
            if (lcl) push(EV_TX, mv, 2'b00);
            if (m_pc >= PL) begin
                m_over = 1'b1;
                push(EV_OVER, mv, 2'b01);
            end else begin
                m_turn = ~m_turn;
                push(EV_FLIP, mv, 2'b00);
            end
        end else if (mv == RESIGN_MV) begin
            if (lcl) push(EV_TX, mv, 2'b00);
            m_over = 1'b1;
            push(EV_OVER, mv, 2'b10);
        end else begin
            acc  = ($urandom_range(0, 9) < 7);
            both = !acc && ($urandom_range(0, 1) == 1);
            if (acc) begin
                m_ko = m_bd;
                m_bd = nb;
                m_mc = m_mc + 1;
                m_pc = 0;
                if (lcl) push(EV_TX, mv, 2'b00);
                if (m_mc == MM) begin
                    m_over = 1'b1;
                    push(EV_OVER, mv, 2'b11);
                end else begin
                    m_turn = ~m_turn;
                    push(EV_FLIP, mv, 2'b00);
                end
            end else begin
                need_tx = 1'b0;
                push(EV_INV, mv, 2'b00);
            end
            wait_for("upd_start", 0, 3);
            check("upd_move", 64'(upd_move), 64'(mv));
            d = $urandom_range(0, 2);
            for (int i = 0; i < d; i++) begin
                move_avail = 1'($urandom_range(0, 1));
                move       = MW'($urandom);
                step();
                move_avail = 1'b0;
            end
            upd_valid   = acc || both;
            upd_invalid = !acc;
            step();
            upd_valid   = 1'b0;
            upd_invalid = 1'b0;
        end

        if (need_tx) begin
            wait_for("tx_ready", 1, 8);
            if ($urandom_range(0, 7) == 0) begin
                do_reset();
                done = 1'b1;
                return;
            end
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                step();
                check("tx_hold", 64'(tx_ready), 64'(1));
            end
            tx_ack = 1'b1;
            step();
            tx_ack = 1'b0;
        end
        wait_for("idle", 2, 8);

        if (m_over) begin
            for (int i = 0; i < 3; i++) begin
                move_avail = 1'b1;
                move       = (i == 0) ? RESIGN_MV : MW'($urandom);
                step();
                move_avail = 1'b0;
            end
            step();
            check("go_state", 64'(state_out), 64'(7'b1000000));
            check("go_flag", 64'(game_over), 64'(1));
            check("go_txrdy", 64'(tx_ready), 64'(0));
            check("go_queue", 64'(q.size()), 64'(0));
            done = 1'b1;
        end
    endtask

    initial begin
        bit done;
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            done = 1'b0;
            for (int mvn = 0; mvn < 24 && !done; mvn++) begin
                play_move(done);
            end
            if (!done) begin
                step();
                check("ep_queue", 64'(q.size()), 64'(0));
            end
        end
        summary_and_finish();
    end

endmodule
